// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode and
// funct constants, datapath select codes and the one-hot instruction class.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [1:0] NPC_PC4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JAL    = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    localparam logic [1:0] A3_RD    = 2'd0;
    localparam logic [1:0] A3_RT    = 2'd1;
    localparam logic [1:0] A3_RA    = 2'd2;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_DM    = 2'd1;
    localparam logic [1:0] WD_EXT   = 2'd2;
    localparam logic [1:0] WD_PC    = 2'd3;

    // Exactly one field is set for any opcode/funct pair.
    typedef struct packed {
        logic rtype_add;
        logic rtype_sub;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
        logic jr;
        logic none;
    } instr_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to one-hot class.
// Anything not recognised (including the all-zero nop) lands in 'none'.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls
);

    // Map the instruction fields to exactly one class bit.
    always_comb begin
        cls = '0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADDU: cls.rtype_add = 1'b1;
                    FN_SUBU: cls.rtype_sub = 1'b1;
                    FN_JR:   cls.jr        = 1'b1;
                    default: cls.none      = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori  = 1'b1;
            OP_LUI:  cls.lui  = 1'b1;
            OP_LW:   cls.lw   = 1'b1;
            OP_SW:   cls.sw   = 1'b1;
            OP_BEQ:  cls.beq  = 1'b1;
            OP_JAL:  cls.jal  = 1'b1;
            default: cls.none = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// combinational per-state enables and selects, plus a retired-instruction count.
// Optional feature macro: MC_CTRL_DM_WAIT_EN adds dm_ready and stalls MEM until it is 1.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        Reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        Zero,
`ifdef MC_CTRL_DM_WAIT_EN
    input  logic        dm_ready,
`endif
    output logic        PC_WE,
    output logic        IR_WE,
    output logic        GRF_WE,
    output logic        DM_WE,
    output logic [1:0]  NPCOp,
    output logic [2:0]  ALUOp,
    output logic        ALU_B_MUX,
    output logic [1:0]  EXTOp,
    output logic [1:0]  GRF_A3_MUX,
    output logic [1:0]  GRF_WD_MUX,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    state_e       state_reg, state_next;
    logic [31:0]  retired_reg;
    instr_class_t cls;
    logic         mem_done;
    logic         pc_we_raw, ir_we_raw, grf_we_raw, dm_we_raw;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls)
    );

`ifdef MC_CTRL_DM_WAIT_EN
    assign mem_done = dm_ready;
`else
    assign mem_done = 1'b1;
`endif

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state_reg <= ST_FETCH;
        else       state_reg <= state_next;
    end

    // Count an instruction each time the sequencer returns to FETCH.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            retired_reg <= '0;
        else if (state_reg != ST_FETCH && state_next == ST_FETCH)
            retired_reg <= retired_reg + 32'd1;
    end

    // Next-state selection by instruction class.
    always_comb begin
        state_next = ST_FETCH;
        unique case (state_reg)
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: begin
                if (cls.lui || cls.jal)
                    state_next = ST_WB;
                else if (cls.rtype_add || cls.rtype_sub || cls.ori ||
                         cls.lw || cls.sw || cls.beq)
                    state_next = ST_EXEC;
                else
                    state_next = ST_FETCH;
            end
            ST_EXEC: begin
                if (cls.lw || cls.sw)
                    state_next = ST_MEM;
                else if (cls.rtype_add || cls.rtype_sub || cls.ori)
                    state_next = ST_WB;
                else
                    state_next = ST_FETCH;
            end
            ST_MEM: begin
                if (!mem_done)
                    state_next = ST_MEM;
                else if (cls.lw)
                    state_next = ST_WB;
                else
                    state_next = ST_FETCH;
            end
            ST_WB:     state_next = ST_FETCH;
            default:   state_next = ST_FETCH;
        endcase
    end

    // Per-state enables and selects; anything not driven below stays 0.
    always_comb begin
        pc_we_raw  = 1'b0;
        ir_we_raw  = 1'b0;
        grf_we_raw = 1'b0;
        dm_we_raw  = 1'b0;
        NPCOp      = NPC_PC4;
        ALUOp      = ALU_ADD;
        ALU_B_MUX  = 1'b0;
        EXTOp      = EXT_ZERO;
        GRF_A3_MUX = A3_RD;
        GRF_WD_MUX = WD_ALU;
        unique case (state_reg)
            ST_FETCH: begin
                ir_we_raw = 1'b1;
                pc_we_raw = 1'b1;
            end
            ST_DECODE: begin
                if (cls.jr) begin
                    pc_we_raw = 1'b1;
                    NPCOp     = NPC_JR;
                end
            end
            ST_EXEC: begin
                if (cls.rtype_sub) begin
                    ALUOp = ALU_SUB;
                end else if (cls.ori) begin
                    ALUOp     = ALU_OR;
                    ALU_B_MUX = 1'b1;
                end else if (cls.lw || cls.sw) begin
                    ALU_B_MUX = 1'b1;
                    EXTOp     = EXT_SIGN;
                end else if (cls.beq) begin
                    ALUOp     = ALU_SUB;
                    pc_we_raw = Zero;
                    NPCOp     = NPC_BRANCH;
                end
            end
            ST_MEM: begin
                dm_we_raw = cls.sw;
            end
            ST_WB: begin
                grf_we_raw = 1'b1;
                if (cls.ori) begin
                    GRF_A3_MUX = A3_RT;
                end else if (cls.lui) begin
                    EXTOp      = EXT_LUI;
                    GRF_A3_MUX = A3_RT;
                    GRF_WD_MUX = WD_EXT;
                end else if (cls.lw) begin
                    GRF_A3_MUX = A3_RT;
                    GRF_WD_MUX = WD_DM;
                end else if (cls.jal) begin
                    GRF_A3_MUX = A3_RA;
                    GRF_WD_MUX = WD_PC;
                    pc_we_raw  = 1'b1;
                    NPCOp      = NPC_JAL;
                end
            end
            default: ;
        endcase
    end

    // Write enables are suppressed for as long as Reset is held.
    assign PC_WE   = pc_we_raw  & ~Reset;
    assign IR_WE   = ir_we_raw  & ~Reset;
    assign GRF_WE  = grf_we_raw & ~Reset;
    assign DM_WE   = dm_we_raw  & ~Reset;
    assign state   = state_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle comparison of every output
// against a path/action model built from the instruction-class rules.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        Reset, Zero;
    logic [5:0]  opcode, funct;
`ifdef MC_CTRL_DM_WAIT_EN
    logic        dm_ready;
`endif
    logic        PC_WE, IR_WE, GRF_WE, DM_WE, ALU_B_MUX;
    logic [1:0]  NPCOp, EXTOp, GRF_A3_MUX, GRF_WD_MUX;
    logic [2:0]  ALUOp, state;
    logic [31:0] retired;

    mc_controller dut (
        .clk        (clk),
        .Reset      (Reset),
        .opcode     (opcode),
        .funct      (funct),
        .Zero       (Zero),
`ifdef MC_CTRL_DM_WAIT_EN
        .dm_ready   (dm_ready),
`endif
        .PC_WE      (PC_WE),
        .IR_WE      (IR_WE),
        .GRF_WE     (GRF_WE),
        .DM_WE      (DM_WE),
        .NPCOp      (NPCOp),
        .ALUOp      (ALUOp),
        .ALU_B_MUX  (ALU_B_MUX),
        .EXTOp      (EXTOp),
        .GRF_A3_MUX (GRF_A3_MUX),
        .GRF_WD_MUX (GRF_WD_MUX),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation vector: state, 4 enables, then the selects.
    typedef struct packed {
        logic [2:0] st;
        logic       pc_we, ir_we, grf_we, dm_we;
        logic [1:0] npc;
        logic [2:0] alu;
        logic       alub;
        logic [1:0] ext, a3, wd;
    } obs_t;

    obs_t act;
    assign act = {state, PC_WE, IR_WE, GRF_WE, DM_WE, NPCOp, ALUOp,
                  ALU_B_MUX, EXTOp, GRF_A3_MUX, GRF_WD_MUX};

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                   K_SW = 5, K_BEQ = 6, K_JAL = 7, K_JR = 8, K_NOP = 9, K_UND = 10;

    int     n_cmp = 0;
    int     n_fail = 0;
    int     model_retired = 0;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, a, e);
        end
    endtask

    // Sequence of states an instruction kind visits, -1 terminated.
    function automatic int path_state(input int kind, input int k);
        int p[6];
        case (kind)
            K_ADDU, K_SUBU, K_ORI: p = '{0, 1, 2, 4, -1, -1};
            K_LUI, K_JAL:          p = '{0, 1, 4, -1, -1, -1};
            K_LW:                  p = '{0, 1, 2, 3, 4, -1};
            K_SW:                  p = '{0, 1, 2, 3, -1, -1};
            K_BEQ:                 p = '{0, 1, 2, -1, -1, -1};
            default:               p = '{0, 1, -1, -1, -1, -1};
        endcase
        return p[k];
    endfunction

    function automatic int path_len(input int kind);
        int n = 0;
        while (path_state(kind, n) >= 0) n++;
        return n;
    endfunction

    // Actions listed for each instruction kind in a given state.
    function automatic obs_t exp_obs(input int kind, input int st, input logic z);
        obs_t o = '0;
        o.st = st[2:0];
        case (st)
            0: begin o.pc_we = 1; o.ir_we = 1; end
            1: if (kind == K_JR) begin o.pc_we = 1; o.npc = 3; end
            2: case (kind)
                   K_SUBU:     o.alu = 1;
                   K_ORI:      begin o.alu = 2; o.alub = 1; end
                   K_LW, K_SW: begin o.alub = 1; o.ext = 1; end
                   K_BEQ:      begin o.alu = 1; o.pc_we = z; o.npc = 1; end
                   default: ;
               endcase
            3: if (kind == K_SW) o.dm_we = 1;
            4: begin
                   o.grf_we = 1;
                   case (kind)
                       K_ORI: o.a3 = 1;
                       K_LUI: begin o.ext = 2; o.a3 = 1; o.wd = 2; end
                       K_LW:  begin o.a3 = 1; o.wd = 1; end
                       K_JAL: begin o.a3 = 2; o.wd = 3; o.pc_we = 1; o.npc = 2; end
                       default: ;
                   endcase
               end
            default: ;
        endcase
        return o;
    endfunction

    task automatic encode(input int kind, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (kind)
            K_ADDU: begin op = 6'h00; fn = 6'h21; end
            K_SUBU: begin op = 6'h00; fn = 6'h23; end
            K_ORI:  op = 6'h0D;
            K_LUI:  op = 6'h0F;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2B;
            K_BEQ:  op = 6'h04;
            K_JAL:  op = 6'h03;
            K_JR:   begin op = 6'h00; fn = 6'h08; end
            K_NOP:  begin op = 6'h00; fn = 6'h00; end
            default: case ($urandom_range(0, 3))
                         0: op = 6'h3F;
                         1: op = 6'h08;
                         2: op = 6'h02;
                         default: begin op = 6'h00; fn = 6'h20; end
                     endcase
        endcase
    endtask

    // Run one instruction from a FETCH negedge; zmode<0 randomises Zero each cycle.
    task automatic run_instr(input int kind, input int zmode);
        logic [5:0] op, fn;
        int n;
        encode(kind, op, fn);
        opcode = op;
        funct  = fn;
        n = path_len(kind);
        for (int k = 0; k < n; k++) begin
            Zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            #1;
            check("cycle_outputs", act, exp_obs(kind, path_state(kind, k), Zero));
            @(negedge clk);
        end
        model_retired++;
        Zero = 1'b0;
        #1;
        check("back_to_fetch", {29'd0, state}, 32'd0);
        check("retired", retired, model_retired);
        $display("instr kind=%0d op=%h fn=%h cycles=%0d retired=%0d", kind, op, fn, n, retired);
    endtask

    typedef struct {
        int   kind;
        logic zero;
        int   cpi;
    } vec_t;

    initial begin
        vec_t vecs[11];
        int   c0, cnt;
        logic [5:0] op, fn;

        vecs = '{'{K_ADDU, 0, 4}, '{K_SUBU, 1, 4}, '{K_ORI, 0, 4}, '{K_LW, 0, 5},
                 '{K_SW, 0, 4}, '{K_LUI, 0, 3}, '{K_BEQ, 1, 3}, '{K_BEQ, 0, 3},
                 '{K_JAL, 0, 3}, '{K_JR, 0, 2}, '{K_UND, 0, 2}};

        Reset = 1'b1; Zero = 1'b0; opcode = '0; funct = '0;
`ifdef MC_CTRL_DM_WAIT_EN
        dm_ready = 1'b1;
`endif
        #2;
        check("reset_state", {29'd0, state}, 32'd0);
        check("reset_retired", retired, 32'd0);
        check("reset_we", {28'd0, PC_WE, IR_WE, GRF_WE, DM_WE}, 32'd0);
        check("reset_sel", {act.npc, act.alu, act.alub, act.ext, act.a3, act.wd}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        check("first_fetch_we", {30'd0, IR_WE, PC_WE}, 32'd3);

        // ori, lui, addu, subu: 15 cycles, four retirements.
        c0 = cyc;
        run_instr(K_ORI, -1);
        run_instr(K_LUI, -1);
        run_instr(K_ADDU, -1);
        run_instr(K_SUBU, -1);
        check("seq1_cycles", cyc - c0, 15);
        check("seq1_retired", retired, 4);

        // lw then sw: 9 cycles, two retirements.
        c0 = cyc;
        run_instr(K_LW, -1);
        run_instr(K_SW, -1);
        check("seq2_cycles", cyc - c0, 9);

        // beq taken then not taken, jal then jr.
        c0 = cyc;
        run_instr(K_BEQ, 1);
        run_instr(K_BEQ, 0);
        check("beq_cycles", cyc - c0, 6);
        c0 = cyc;
        run_instr(K_JAL, -1);
        run_instr(K_JR, -1);
        check("jal_jr_cycles", cyc - c0, 5);

        // Reset in the middle of addu's EXEC.
        encode(K_ADDU, op, fn);
        opcode = op; funct = fn;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_exec", {29'd0, state}, 32'd2);
        Reset = 1'b1;
        #1;
        check("midreset_state", {29'd0, state}, 32'd0);
        check("midreset_retired", retired, 32'd0);
        check("midreset_we", {28'd0, PC_WE, IR_WE, GRF_WE, DM_WE}, 32'd0);
        @(posedge clk);
        #1;
        check("held_reset_we", {28'd0, PC_WE, IR_WE, GRF_WE, DM_WE}, 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        model_retired = 0;
        #1;
        check("post_reset_fetch", {30'd0, IR_WE, PC_WE}, 32'd3);

        // Table: CPI measured from the DUT's own state sequence.
        foreach (vecs[i]) begin
            encode(vecs[i].kind, op, fn);
            opcode = op; funct = fn; Zero = vecs[i].zero;
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
                #1;
            end while (state != 3'd0 && cnt < 10);
            model_retired++;
            check("table_cpi", cnt, vecs[i].cpi);
            check("table_retired", retired, model_retired);
            $display("vec %0d kind=%0d cpi=%0d retired=%0d", i, vecs[i].kind, cnt, retired);
        end

        // Random instruction stream.
        for (int i = 0; i < 250; i++) run_instr($urandom_range(0, 10), -1);

`ifdef MC_CTRL_DM_WAIT_EN
        // sw with dm_ready low for three MEM cycles.
        encode(K_SW, op, fn);
        opcode = op; funct = fn;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            dm_ready = (k == 3);
            #1;
            check("wait_mem_state", {29'd0, state}, 32'd3);
            check("wait_dm_we", {31'd0, DM_WE}, 32'd1);
            check("wait_retired", retired, model_retired);
            @(negedge clk);
        end
        model_retired++;
        #1;
        check("wait_exit_state", {29'd0, state}, 32'd0);
        check("wait_exit_retired", retired, model_retired);
        $display("instr sw with wait retired=%0d", retired);
        dm_ready = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
